// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared state encoding, ALU function codes and width helper for alu_arbiter.
// Rev 1.0
`default_nettype none

package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] F_AND = 3'b000;
  localparam logic [2:0] F_OR  = 3'b001;
  localparam logic [2:0] F_ADD = 3'b010;
  localparam logic [2:0] F_SUB = 3'b110;
  localparam logic [2:0] F_SLT = 3'b111;

  function automatic int ptr_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester handshakes and shared-ALU connection of alu_arbiter.
// Rev 1.0
`default_nettype none

interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*3-1:0]     req_f;
  logic [NREQ-1:0]       resp_valid;
  logic [NREQ-1:0]       resp_ready;
  logic [WIDTH-1:0]      resp_y;
  logic                  resp_c;
  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic [2:0]            alu_f;
  logic [WIDTH-1:0]      alu_y;
  logic                  alu_c;

  modport slave (
    input  req_valid, req_a, req_b, req_f, resp_ready, alu_y, alu_c,
    output req_ready, resp_valid, resp_y, resp_c, alu_a, alu_b, alu_f
  );

  modport master (
    output req_valid, req_a, req_b, req_f, resp_ready, alu_y, alu_c,
    input  req_ready, resp_valid, resp_y, resp_c, alu_a, alu_b, alu_f
  );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector, first request at or after ptr (mod NREQ).
// Rev 1.0
`default_nettype none

module rr_picker #(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [PTR_W-1:0] gnt_o,
  output logic             any_o
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  // Scan farthest-first so the candidate closest to ptr is the last (winning) assignment.
  always_comb begin
    gnt_o = '0;
    any_o = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_i} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NREQ)) begin
        sum = sum - (PTR_W+1)'(NREQ);
      end
      idx = sum[PTR_W-1:0];
      if (req_i[idx]) begin
        gnt_o = idx;
        any_o = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU, one transaction in flight.
// Rev 1.0 -- optional per-requester grant counters under ALU_ARB_PERF_CNT_EN.
`default_nettype none

module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2
) (
  input  logic               clk,
  input  logic               reset,
  alu_arbiter_if.slave       bus
`ifdef ALU_ARB_PERF_CNT_EN
  ,
  output logic [NREQ*16-1:0] grant_cnt
`endif
);

  localparam int PTR_W = ptr_width(NREQ);

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2:0]         f_q, f_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               c_q, c_d;
  logic [PTR_W-1:0]   pick_gnt;
  logic               pick_any;
  logic               accept;

  rr_picker #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .any_o (pick_any)
  );

  assign accept     = (state_q == IDLE) && pick_any;
  assign bus.alu_a  = a_q;
  assign bus.alu_b  = b_q;
  assign bus.alu_f  = f_q;
  assign bus.resp_y = y_q;
  assign bus.resp_c = c_q;

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    gnt_d          = gnt_q;
    a_d            = a_q;
    b_d            = b_q;
    f_d            = f_q;
    y_d            = y_q;
    c_d            = c_q;
    bus.req_ready  = '0;
    bus.resp_valid = '0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          bus.req_ready[pick_gnt] = 1'b1;
          gnt_d   = pick_gnt;
          a_d     = bus.req_a[int'(pick_gnt)*WIDTH +: WIDTH];
          b_d     = bus.req_b[int'(pick_gnt)*WIDTH +: WIDTH];
          f_d     = bus.req_f[int'(pick_gnt)*3 +: 3];
          state_d = EXEC;
        end
      end
      EXEC: begin
        y_d     = bus.alu_y;
        c_d     = bus.alu_c;
        state_d = RESP;
      end
      RESP: begin
        bus.resp_valid[gnt_q] = 1'b1;
        if (bus.resp_ready[gnt_q]) begin
          state_d = IDLE;
          ptr_d   = (int'(gnt_q) == NREQ - 1) ? '0 : gnt_q + PTR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      y_q     <= '0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      f_q     <= f_d;
      y_q     <= y_d;
      c_q     <= c_d;
    end
  end

`ifdef ALU_ARB_PERF_CNT_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_perf_cnt
    logic [15:0] cnt_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
      end else if (accept && (pick_gnt == PTR_W'(i))) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
    assign grant_cnt[i*16 +: 16] = cnt_q;
  end
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

`default_nettype wire
